// File: rtl/instr_cache_pkg.sv
// Shared definitions for the L0 instruction cache: controller state encoding
// and block geometry helpers used by both the controller and the datapath.
package instr_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT
  } state_e;

  function automatic int words_in_block(input int ram_width);
    return ram_width / 32;
  endfunction

  // Tag covers every address bit above the block offset.
  function automatic int tag_w(input int ram_width);
    return 30 - $clog2(words_in_block(ram_width));
  endfunction

endpackage

// File: rtl/instr_cache_rr_ptr.sv
// Round-robin victim line pointer; wraps naturally at 2**W lines.
module instr_cache_rr_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] idx
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (advance) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/instr_cache_ctrl.sv
// L0 instruction cache control: grants hits, runs single-outstanding block
// refills on misses, and owns the round-robin victim pointer.
module instr_cache_ctrl
  import instr_cache_pkg::*;
#(
  parameter  int LOG2_NUM_BLKS = 3,
  parameter  int RAM_WIDTH     = 128,
  localparam int TAG_W         = tag_w(RAM_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soft_rst_i,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic                     search_o,
  output logic                     new_rvalid_o,
  output logic                     new_rdata_o,
  output logic [TAG_W-1:0]         tag_d_o,
  output logic [LOG2_NUM_BLKS-1:0] rplc_line_idx_o,
  input  logic                     miss_i,
  input  logic                     data_ready_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i
);

  localparam int OFS_W = 32 - TAG_W;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_nxt;
  logic             flush_pend_q, flush_pend_nxt;
  logic             suppress;
  logic             ptr_advance, ptr_clear;

  // Word/byte offset bits never reach the controller's decisions.
  logic addr_lo_unused;
  assign addr_lo_unused = ^instr_addr_i[OFS_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_nxt;
      flush_pend_q <= flush_pend_nxt;
    end
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    tag_nxt        = tag_q;
    flush_pend_nxt = flush_pend_q;
    search_o       = 1'b0;
    instr_gnt_o    = 1'b0;
    new_rdata_o    = 1'b0;
    new_rvalid_o   = 1'b0;
    mem_req_o      = 1'b0;
    suppress       = 1'b0;
    ptr_advance    = 1'b0;
    ptr_clear      = soft_rst_i;

    unique case (state_q)
      IDLE: begin
        search_o    = instr_req_i & ~soft_rst_i;
        instr_gnt_o = search_o & ~miss_i;
        if (search_o && miss_i) begin
          tag_nxt = instr_addr_i[31:OFS_W];
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_o = 1'b1;
        if (soft_rst_i) flush_pend_nxt = 1'b1;
        if (mem_gnt_i)  state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (soft_rst_i) flush_pend_nxt = 1'b1;
        if (mem_rvalid_i) begin
          // A flush seen during the refill discards the block; the held
          // request then re-misses from IDLE.
          suppress       = flush_pend_q | soft_rst_i;
          search_o       = instr_req_i;
          instr_gnt_o    = instr_req_i & ~suppress;
          new_rdata_o    = ~suppress;
          new_rvalid_o   = ~suppress;
          ptr_advance    = ~suppress;
          flush_pend_nxt = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o     = mem_req_o ? {tag_q, {OFS_W{1'b0}}} : 32'h0;
  assign tag_d_o        = tag_q;
  assign instr_rvalid_o = data_ready_i;

  instr_cache_rr_ptr #(
    .W (LOG2_NUM_BLKS)
  ) u_rr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (ptr_advance),
    .clear   (ptr_clear),
    .idx     (rplc_line_idx_o)
  );

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Self-checking bench for instr_cache_ctrl: directed plan steps plus random
// fetches checked against a FIFO-of-resident-blocks reference model.
module tb_instr_cache_ctrl;

  localparam int TAG_W = 28;
  localparam int NB    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              soft_rst_i = 1'b0;
  logic              instr_req_i = 1'b0;
  logic [31:0]       instr_addr_i = 32'h0;
  logic              instr_gnt_o, instr_rvalid_o, search_o;
  logic              new_rvalid_o, new_rdata_o;
  logic [TAG_W-1:0]  tag_d_o;
  logic [2:0]        rplc_line_idx_o;
  logic              miss_i, data_ready_i;
  logic              mem_req_o;
  logic [31:0]       mem_addr_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  instr_cache_ctrl #(
    .LOG2_NUM_BLKS (3),
    .RAM_WIDTH     (128)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .soft_rst_i      (soft_rst_i),
    .instr_req_i     (instr_req_i),
    .instr_addr_i    (instr_addr_i),
    .instr_gnt_o     (instr_gnt_o),
    .instr_rvalid_o  (instr_rvalid_o),
    .search_o        (search_o),
    .new_rvalid_o    (new_rvalid_o),
    .new_rdata_o     (new_rdata_o),
    .tag_d_o         (tag_d_o),
    .rplc_line_idx_o (rplc_line_idx_o),
    .miss_i          (miss_i),
    .data_ready_i    (data_ready_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: tag array written on fill, flushed by soft reset.
  logic [TAG_W-1:0] dp_tag [NB];
  logic [NB-1:0]    dp_vld;
  logic [TAG_W-1:0] req_tag;
  logic             dp_hit;

  assign req_tag = instr_addr_i[31:4];

  always_comb begin
    dp_hit = 1'b0;
    for (int i = 0; i < NB; i++)
      if (dp_vld[i] && dp_tag[i] == req_tag) dp_hit = 1'b1;
    miss_i = search_o & ~dp_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_vld       <= '0;
      data_ready_i <= 1'b0;
    end else begin
      data_ready_i <= search_o & (dp_hit | (new_rvalid_o && tag_d_o == req_tag));
      if (soft_rst_i) dp_vld <= '0;
      else if (new_rdata_o) begin
        dp_vld[rplc_line_idx_o] <= 1'b1;
        dp_tag[rplc_line_idx_o] <= tag_d_o;
      end
    end
  end

  // Reference: resident blocks are the last NB refilled tags, oldest evicted.
  logic [TAG_W-1:0] ref_q [$];
  int               ref_fills = 0;
  logic [2:0]       victim_seq [$];

  function automatic bit ref_has(input logic [TAG_W-1:0] t);
    foreach (ref_q[i]) if (ref_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_fill(input logic [TAG_W-1:0] t);
    ref_q.push_back(t);
    if (ref_q.size() > NB) void'(ref_q.pop_front());
    ref_fills++;
  endtask

  task automatic ref_flush();
    ref_q.delete();
    ref_fills = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete fetch; gdly = idle cycles before mem gnt, rdly = cycles gnt->rvalid.
  task automatic fetch(input logic [31:0] a, input int gdly, input int rdly);
    logic [TAG_W-1:0] t;
    bit               hit;
    logic [2:0]       v;
    t   = a[31:4];
    hit = ref_has(t);
    v   = 3'(ref_fills % NB);
    instr_req_i  = 1'b1;
    instr_addr_i = a;
    #1;
    check("c0_search", search_o, 1);
    check("c0_gnt", instr_gnt_o, hit);
    check("c0_mem_req", mem_req_o, 0);
    tick();
    if (!hit) begin
      for (int k = 0; k <= gdly; k++) begin
        mem_gnt_i = (k == gdly);
        #1;
        check("req_mem_req", mem_req_o, 1);
        check("req_mem_addr", mem_addr_o, {t, 4'h0});
        check("req_search", search_o, 0);
        check("req_rplc", rplc_line_idx_o, v);
        tick();
      end
      mem_gnt_i = 1'b0;
      for (int k = 1; k < rdly; k++) begin
        #1;
        check("wait_mem_req", mem_req_o, 0);
        check("wait_search", search_o, 0);
        check("wait_new_rdata", new_rdata_o, 0);
        tick();
      end
      mem_rvalid_i = 1'b1;
      #1;
      check("fill_new_rdata", new_rdata_o, 1);
      check("fill_new_rvalid", new_rvalid_o, 1);
      check("fill_tag_d", tag_d_o, t);
      check("fill_rplc", rplc_line_idx_o, v);
      check("fill_gnt", instr_gnt_o, 1);
      victim_seq.push_back(rplc_line_idx_o);
      ref_fill(t);
      tick();
      mem_rvalid_i = 1'b0;
    end
    instr_req_i = 1'b0;
    #1;
    check("rvalid", instr_rvalid_o, 1);
    check("rplc_after", rplc_line_idx_o, ref_fills % NB);
    check("idle_mem_req", mem_req_o, 0);
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_search", search_o, 0);
    check("rst_gnt", instr_gnt_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_new_rdata", new_rdata_o, 0);
    check("rst_tag_d", tag_d_o, 0);
    check("rst_rplc", rplc_line_idx_o, 0);
    rst_n = 1'b1;
    tick();

    // 1. Reset asserted while waiting for refill data
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_3000;
    #1;
    check("t1_c0_gnt", instr_gnt_o, 0);
    tick();
    mem_gnt_i = 1'b1;
    #1;
    check("t1_mem_req", mem_req_o, 1);
    tick();
    mem_gnt_i   = 1'b0;
    rst_n       = 1'b0;
    instr_req_i = 1'b0;
    #1;
    check("t1_rst_mem_req", mem_req_o, 0);
    check("t1_rst_search", search_o, 0);
    check("t1_rst_tag_d", tag_d_o, 0);
    check("t1_rst_new_rdata", new_rdata_o, 0);
    tick();
    rst_n        = 1'b1;
    mem_rvalid_i = 1'b1;
    #1;
    check("t1_late_new_rdata", new_rdata_o, 0);
    check("t1_late_new_rvalid", new_rvalid_o, 0);
    check("t1_late_mem_req", mem_req_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    tick();

    // 2. Cold miss, gnt in the first request cycle, rvalid two cycles after gnt
    fetch(32'h0000_1004, 0, 2);
    check("t2_victim", victim_seq[0], 0);

    // 3. Hit in the freshly filled block
    fetch(32'h0000_1008, 0, 1);

    // Soft reset in IDLE blocks search/gnt and clears the victim pointer
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_1008;
    soft_rst_i   = 1'b1;
    #1;
    check("sr_idle_search", search_o, 0);
    check("sr_idle_gnt", instr_gnt_o, 0);
    tick();
    soft_rst_i  = 1'b0;
    instr_req_i = 1'b0;
    #1;
    check("sr_idle_rplc", rplc_line_idx_o, 0);
    ref_flush();
    tick();

    // 4. Nine misses to distinct blocks walk the victim pointer 0..7,0
    victim_seq.delete();
    for (int i = 0; i < 9; i++) fetch(32'h0000_2000 + 32'(i * 16), i % 2, 1 + i % 3);
    for (int i = 0; i < 9; i++) check($sformatf("t4_seq%0d", i), victim_seq[i], i % NB);

    // 5. Memory stalls gnt for five cycles
    fetch(32'h0000_5000, 5, 2);

    // 6. Soft reset pulse while waiting for refill data
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_1004;
    #1;
    check("t6_c0_gnt", instr_gnt_o, 0);
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i  = 1'b0;
    soft_rst_i = 1'b1;
    #1;
    check("t6_wait_search", search_o, 0);
    tick();
    soft_rst_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    check("t6_fill_new_rdata", new_rdata_o, 0);
    check("t6_fill_new_rvalid", new_rvalid_o, 0);
    check("t6_fill_gnt", instr_gnt_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    ref_flush();
    fetch(32'h0000_1004, 0, 1);

    // Random fetches over a small block pool to mix hits, misses and evictions
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'h0004_0000 + ($urandom_range(11) << 4) + ($urandom_range(3) << 2);
      fetch(a, $urandom_range(3), 1 + $urandom_range(2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_cache_ctrl.md
Name: instr_cache_ctrl

Overview:
Control stage of the L0 instruction cache. It sits between the core fetch port, the cache datapath, and the instruction memory port.
- Drives the datapath strobes: search, new_rvalid, new_rdata, fill tag, victim line index.
- Grants core fetch requests on a hit.
- On a miss, runs a single-outstanding block refill from memory, then completes the stalled fetch.
- Owns the round-robin victim pointer.

Parameters:
LOG2_NUM_BLKS, 3, log2 of the number of cache lines; sets the victim pointer width.
RAM_WIDTH, 128, memory block width in bits (32 or 128). Derived: WORDS = RAM_WIDTH/32; TAG_W = 30 - log2(WORDS).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
soft_rst_i  in  1  cache flush request (same signal seen by the datapath)
instr_req_i  in  1  core fetch request; addr held stable until gnt
instr_addr_i  in  32  core fetch address
instr_gnt_o  out  1  fetch accepted
instr_rvalid_o  out  1  fetch data valid on the datapath data output
search_o  out  1  datapath search strobe
new_rvalid_o  out  1  datapath fill-cycle strobe
new_rdata_o  out  1  datapath write strobe for the refill block
tag_d_o  out  TAG_W  tag of the refill block
rplc_line_idx_o  out  LOG2_NUM_BLKS  victim line
miss_i  in  1  datapath miss, combinational in the search cycle
data_ready_i  in  1  datapath registered hit, one cycle after search
mem_req_o  out  1  memory block request
mem_addr_o  out  32  block-aligned memory address
mem_gnt_i  in  1  memory accepts request
mem_rvalid_i  in  1  refill block valid on the datapath data input

Behaviour:
- Reset: all outputs 0, state IDLE, victim pointer 0, tag register 0, flush_pend 0.
- Cycle-level behaviour is independent of the LOG2_NUM_BLKS and RAM_WIDTH values.

FSM states:
- IDLE
  - search_o = instr_req_i & ~soft_rst_i.
  - instr_gnt_o = search_o & ~miss_i.
  - If search_o & miss_i: latch tag = instr_addr_i[31:32-TAG_W], go to MISS_REQ.
- MISS_REQ
  - mem_req_o = 1; mem_addr_o = {tag, zeros}.
  - mem_req_o and mem_addr_o stay stable until mem_gnt_i.
  - On mem_gnt_i, go to MISS_WAIT.
- MISS_WAIT
  - Wait for mem_rvalid_i, which arrives at least 1 cycle after gnt.
  - When it arrives (fill cycle):
    - new_rdata_o = new_rvalid_o = 1; tag_d_o = tag.
    - search_o = instr_req_i; instr_gnt_o = search_o. The tag match in the datapath guarantees a hit.
    - Victim pointer increments, wrapping from NUM_BLKS-1 to 0.
    - Go to IDLE.

Timing and outputs:
- instr_rvalid_o = data_ready_i, combinational pass-through.
- Hit latency: gnt in the request cycle, rvalid the next cycle.
- Miss latency: 1 cycle to MISS_REQ, plus memory latency, plus 1 cycle.
- rplc_line_idx_o = victim pointer at all times, so it is stable through the fill cycle.
- tag_d_o is driven from the tag register at all times.
- search_o = 0 in MISS_REQ. Outside the fill cycle, search_o = 0 in MISS_WAIT and new_rdata_o = new_rvalid_o = 0.

Boundary conditions:
- soft_rst_i in IDLE: no search, no gnt; victim pointer cleared to 0.
- soft_rst_i in MISS_REQ or MISS_WAIT:
  - Set flush_pend and clear the victim pointer.
  - The memory transaction still completes.
  - In the fill cycle, new_rdata_o, new_rvalid_o and instr_gnt_o are suppressed.
  - Return to IDLE and clear flush_pend; the core's held request re-misses.
- instr_req_i dropped during a miss is a protocol violation. The fill still completes and no gnt is issued.
- mem_rvalid_i outside MISS_WAIT is ignored.
- Only one outstanding memory request at a time.

Decomposition:
Shared package instr_cache_pkg:
- State enum {IDLE, MISS_REQ, MISS_WAIT}.
- Functions tag_w(RAM_WIDTH) and words_in_block(RAM_WIDTH), shared with the datapath.

Sub-module:
- instr_cache_rr_ptr: the victim pointer, with inputs advance and clear and an output idx.
- The FSM stays in instr_cache_ctrl.

Test Plan:
(All cases: RAM_WIDTH=128, TAG_W=28.)
1. Reset mid-miss (rst_n low in MISS_WAIT) -> all outputs 0 and state IDLE next cycle; a later mem_rvalid_i produces no new_rdata_o.
2. Cold miss at 0x0000_1004, memory gnt 1 cycle later, rvalid 2 cycles after gnt:
   - C0: search_o=1, miss_i=1, gnt=0.
   - C1: mem_req_o=1, mem_addr_o=0x0000_1000.
   - Fill cycle: new_rdata_o=1, tag_d_o=0x0000100, rplc_line_idx_o=0, gnt=1.
   - Next cycle: rvalid=1; rplc_line_idx_o becomes 1.
3. Hit at 0x0000_1008 after test 2 -> gnt in the same cycle, rvalid the next cycle, mem_req_o stays 0.
4. Nine misses to distinct blocks -> rplc_line_idx_o sequence 0,1,...,7,0.
5. mem_gnt_i held low for 5 cycles -> mem_req_o=1 and mem_addr_o unchanged for all 5 cycles, no search_o.
6. soft_rst_i pulse in MISS_WAIT:
   - The fill cycle shows new_rdata_o=0 and gnt=0.
   - Then IDLE, a re-miss on the same address, and a new mem_req_o to 0x0000_1000 with rplc_line_idx_o=0.
